// File: rtl/aes_key_sched_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl_if
// Control and read-port bundle between the cipher datapath (master) and the
// AES-128 key-schedule controller (slave).
//
// Signals:
//   start      master->slave  single-cycle load-and-expand request
//   clear      master->slave  synchronous zeroize of all round keys
//   key_in     master->slave  cipher key, sampled when start is accepted
//   rk_rd_idx  master->slave  round-key read index 0..10
//   busy       slave->master  expansion in progress
//   ready      slave->master  complete schedule held
//   done       slave->master  one-cycle pulse at end of expansion
//   rk_rd_data slave->master  registered round key (1-cycle read latency)
//   state_dbg  slave->master  FSM state for observation (0 IDLE, 1 EXPAND,
//                             2 READY)
//
// Handshake: start is a fire-and-forget request with no back-pressure. It is
// accepted on any rising edge where it is high and the controller is in IDLE
// or READY with clear low; in EXPAND it is ignored. Acceptance is visible as
// busy going high after that edge, and completion as done/ready after the
// tenth expansion edge.
// ---------------------------------------------------------------------------
interface aes_key_sched_ctrl_if;
  logic         start;
  logic         clear;
  logic [127:0] key_in;
  logic         busy;
  logic         ready;
  logic         done;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic [1:0]   state_dbg;

  modport master (
    output start, clear, key_in, rk_rd_idx,
    input  busy, ready, done, rk_rd_data, state_dbg
  );

  modport slave (
    input  start, clear, key_in, rk_rd_idx,
    output busy, ready, done, rk_rd_data, state_dbg
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl
// Sequential AES-128 key schedule. A start loads the cipher key into rk[0];
// one combinational round-key generator (gen_key) is then stepped once per
// clock, writing rk[1]..rk[10]. All 11 round keys are held for the cipher
// datapath, which reads them through a registered indexed port.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    aes_key_sched_ctrl_if.slave (start/clear/key_in, busy/ready/done,
//          rk_rd_idx/rk_rd_data, state_dbg)
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_key_sched_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] MAX_IDX  = 4'(NUM_ROUNDS);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q;
  logic             busy_q, ready_q, done_q;
  logic [KEY_W-1:0] rk_q [0:NUM_ROUNDS];
  logic [KEY_W-1:0] rd_q;
  logic [KEY_W-1:0] gen_out;
  logic             do_load, do_step, do_finish, do_zero;

  // ---- GF(2^8) helpers: S-box as multiplicative inverse + affine map ----
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y, inv, b;
    y   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      y   = gf_mul(y, y);
      inv = gf_mul(inv, y);
    end
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One AES-128 expansion round: round r consumes rcon[r].
  function automatic logic [127:0] gen_key(input logic [3:0] r, input logic [127:0] k);
    logic [31:0] t, n0, n1, n2, n3;
    // RotWord then SubWord on the last word of the previous round key
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])}
         ^ {rcon(r), 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign gen_out = gen_key(cnt_q, rk_q[cnt_q]);

  // ---- FSM: next state and per-cycle actions ----
  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_step   = 1'b0;
    do_finish = 1'b0;
    do_zero   = 1'b0;
    if (bus.clear) begin
      // clear outranks start in every state
      do_zero = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, READY: begin
          if (bus.start) begin
            do_load = 1'b1;
            state_d = EXPAND;
          end
        end
        EXPAND: begin
          do_step = 1'b1;
          if (cnt_q == LAST_CNT) begin
            do_finish = 1'b1;
            state_d   = READY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= do_finish;
      if (do_zero) begin
        cnt_q   <= 4'd0;
        busy_q  <= 1'b0;
        ready_q <= 1'b0;
      end else if (do_load) begin
        cnt_q   <= 4'd0;
        busy_q  <= 1'b1;
        ready_q <= 1'b0;
      end else if (do_finish) begin
        cnt_q   <= 4'd0;
        busy_q  <= 1'b0;
        ready_q <= 1'b1;
      end else if (do_step) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  // ---- Round-key register file ----
  // A reload only rewrites rk[0]; rk[1..10] keep stale values until each is
  // overwritten by the new expansion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
    end else if (do_zero) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
    end else begin
      if (do_load) rk_q[0] <= bus.key_in;
      if (do_step) begin
        for (int i = 1; i <= NUM_ROUNDS; i++) begin
          if (cnt_q == 4'(i - 1)) rk_q[i] <= gen_out;
        end
      end
    end
  end

  // ---- Registered read port; a same-edge write is seen on the next read ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (bus.rk_rd_idx <= MAX_IDX) begin
      rd_q <= rk_q[bus.rk_rd_idx];
    end else begin
      rd_q <= '0;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.ready      = ready_q;
  assign bus.done       = done_q;
  assign bus.rk_rd_data = rd_q;
  assign bus.state_dbg  = state_q;

endmodule
